// File: rtl/vedic_mul_pipe_if.sv
// Operand/result handshake bundle for the pipelined Vedic multiplier.
// The master drives operands and consumer readiness; the slave is the multiplier.
interface vedic_mul_pipe_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] prod_low;
  logic [WIDTH-1:0] prod_high;
  logic             out_signed;

  modport master (
    output in_valid, in_a, in_b, in_signed, out_ready,
    input  in_ready, out_valid, prod_low, prod_high, out_signed
  );

  modport slave (
    input  in_valid, in_a, in_b, in_signed, out_ready,
    output in_ready, out_valid, prod_low, prod_high, out_signed
  );
endinterface

// File: rtl/vedic_mul_pipe.sv
// Two-stage Urdhva-Tiryakbhyam multiplier with signed/unsigned mode and
// valid/ready flow control; sub-products recurse down to BASE_W-bit leaves.
module vedic_mul_core #(
  parameter int W      = 4,
  parameter int BASE_W = 4
) (
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  generate
    if (W <= BASE_W) begin : g_leaf
      assign p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    end else begin : g_split
      localparam int H = W / 2;
      logic [W-1:0]   pll_s, plh_s, phl_s, phh_s;
      logic [W+H-1:0] x_s, y_s, z_s, sum_s, cry_s;

      vedic_mul_core #(.W(H), .BASE_W(BASE_W)) u_ll (.a(a[H-1:0]), .b(b[H-1:0]), .p(pll_s));
      vedic_mul_core #(.W(H), .BASE_W(BASE_W)) u_lh (.a(a[H-1:0]), .b(b[W-1:H]), .p(plh_s));
      vedic_mul_core #(.W(H), .BASE_W(BASE_W)) u_hl (.a(a[W-1:H]), .b(b[H-1:0]), .p(phl_s));
      vedic_mul_core #(.W(H), .BASE_W(BASE_W)) u_hh (.a(a[W-1:H]), .b(b[W-1:H]), .p(phh_s));

      // high term and low carry-out never overlap, so they share one CSA operand
      assign x_s   = {phh_s, pll_s[W-1:H]};
      assign y_s   = {{H{1'b0}}, plh_s};
      assign z_s   = {{H{1'b0}}, phl_s};
      assign sum_s = x_s ^ y_s ^ z_s;
      assign cry_s = ((x_s & y_s) | (x_s & z_s) | (y_s & z_s)) << 1'b1;
      assign p     = {sum_s + cry_s, pll_s[H-1:0]};
    end
  endgenerate
endmodule

module vedic_mul_pipe #(
  parameter int WIDTH  = 8,
  parameter int BASE_W = 4
) (
  input logic            clk,
  input logic            rst,
  vedic_mul_pipe_if.slave bus
);
  localparam int H = WIDTH / 2;

  logic               s1_adv_s, s2_adv_s;
  logic               sa_s, sb_s;
  logic [WIDTH-1:0]   a_mag_s, b_mag_s;
  logic [WIDTH-1:0]   pll_s, plh_s, phl_s, phh_s;
  logic               s1_valid_r, s1_neg_r, s1_signed_r;
  logic [WIDTH-1:0]   s1_a_mag_r, s1_b_mag_r;
  logic [WIDTH-1:0]   s1_pll_r, s1_plh_r, s1_phl_r, s1_phh_r;
  logic [WIDTH+H-1:0] csa_x_s, csa_y_s, csa_z_s, csa_sum_s, csa_cry_s;
  logic [2*WIDTH-1:0] mag_prod_s, result_s;
  logic               neg_s;
  logic               s2_valid_r, s2_signed_r;
  logic [2*WIDTH-1:0] s2_prod_r;

  // Stage advance conditions; a drained output frees the whole pipe in one cycle.
  always_comb begin
    s2_adv_s = !s2_valid_r || bus.out_ready;
    s1_adv_s = !s1_valid_r || s2_adv_s;
  end

  assign bus.in_ready   = s1_adv_s;
  assign bus.out_valid  = s2_valid_r;
  assign bus.prod_low   = s2_prod_r[WIDTH-1:0];
  assign bus.prod_high  = s2_prod_r[2*WIDTH-1:WIDTH];
  assign bus.out_signed = s2_signed_r;

  // Operand magnitudes; the most-negative value maps to 2^(WIDTH-1), which still fits.
  always_comb begin
    sa_s = bus.in_signed & bus.in_a[WIDTH-1];
    sb_s = bus.in_signed & bus.in_b[WIDTH-1];
    if (sa_s) a_mag_s = ~bus.in_a + WIDTH'(1);
    else      a_mag_s = bus.in_a;
    if (sb_s) b_mag_s = ~bus.in_b + WIDTH'(1);
    else      b_mag_s = bus.in_b;
  end

  vedic_mul_core #(.W(H), .BASE_W(BASE_W)) u_ll (.a(a_mag_s[H-1:0]),     .b(b_mag_s[H-1:0]),     .p(pll_s));
  vedic_mul_core #(.W(H), .BASE_W(BASE_W)) u_lh (.a(a_mag_s[H-1:0]),     .b(b_mag_s[WIDTH-1:H]), .p(plh_s));
  vedic_mul_core #(.W(H), .BASE_W(BASE_W)) u_hl (.a(a_mag_s[WIDTH-1:H]), .b(b_mag_s[H-1:0]),     .p(phl_s));
  vedic_mul_core #(.W(H), .BASE_W(BASE_W)) u_hh (.a(a_mag_s[WIDTH-1:H]), .b(b_mag_s[WIDTH-1:H]), .p(phh_s));

  // S1: magnitudes, result sign, mode and the four half-width sub-products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r  <= 1'b0;
      s1_neg_r    <= 1'b0;
      s1_signed_r <= 1'b0;
      s1_a_mag_r  <= '0;
      s1_b_mag_r  <= '0;
      s1_pll_r    <= '0;
      s1_plh_r    <= '0;
      s1_phl_r    <= '0;
      s1_phh_r    <= '0;
    end else if (s1_adv_s) begin
      s1_valid_r <= bus.in_valid;
      if (bus.in_valid) begin
        s1_neg_r    <= sa_s ^ sb_s;
        s1_signed_r <= bus.in_signed;
        s1_a_mag_r  <= a_mag_s;
        s1_b_mag_r  <= b_mag_s;
        s1_pll_r    <= pll_s;
        s1_plh_r    <= plh_s;
        s1_phl_r    <= phl_s;
        s1_phh_r    <= phh_s;
      end
    end
  end

  // Combine sub-products and apply the sign; a zero magnitude is never negated.
  always_comb begin
    csa_x_s    = {s1_phh_r, s1_pll_r[WIDTH-1:H]};
    csa_y_s    = {{H{1'b0}}, s1_plh_r};
    csa_z_s    = {{H{1'b0}}, s1_phl_r};
    csa_sum_s  = csa_x_s ^ csa_y_s ^ csa_z_s;
    csa_cry_s  = ((csa_x_s & csa_y_s) | (csa_x_s & csa_z_s) | (csa_y_s & csa_z_s)) << 1'b1;
    mag_prod_s = {csa_sum_s + csa_cry_s, s1_pll_r[H-1:0]};
    neg_s      = s1_neg_r & (|s1_a_mag_r) & (|s1_b_mag_r);
    if (neg_s) result_s = ~mag_prod_s + (2*WIDTH)'(1);
    else       result_s = mag_prod_s;
  end

  // S2: output register, held while the consumer stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_r  <= 1'b0;
      s2_signed_r <= 1'b0;
      s2_prod_r   <= '0;
    end else if (s2_adv_s) begin
      s2_valid_r <= s1_valid_r;
      if (s1_valid_r) begin
        s2_prod_r   <= result_s;
        s2_signed_r <= s1_signed_r;
      end
    end
  end
endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Self-checking bench: WIDTH=8 directed/random/backpressure/reset tests plus a
// WIDTH=4/16/32 sweep, all checked against integer-arithmetic expectations.
module tb_vedic_mul_pipe;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  vedic_mul_pipe_if #(.WIDTH(8))  b8();
  vedic_mul_pipe_if #(.WIDTH(4))  b4();
  vedic_mul_pipe_if #(.WIDTH(16)) b16();
  vedic_mul_pipe_if #(.WIDTH(32)) b32();

  vedic_mul_pipe #(.WIDTH(8),  .BASE_W(4)) u8  (.clk(clk), .rst(rst), .bus(b8));
  vedic_mul_pipe #(.WIDTH(4),  .BASE_W(4)) u4  (.clk(clk), .rst(rst), .bus(b4));
  vedic_mul_pipe #(.WIDTH(16), .BASE_W(4)) u16 (.clk(clk), .rst(rst), .bus(b16));
  vedic_mul_pipe #(.WIDTH(32), .BASE_W(4)) u32 (.clk(clk), .rst(rst), .bus(b32));

  int checks = 0;
  int errors = 0;
  logic [64:0] q8[$], q4[$], q16[$], q32[$];

  task automatic chk(input string tag, input logic [64:0] obs, input logic [64:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Exact product of w-bit operands, interpreted per mode, reduced to 2*w bits.
  function automatic logic [63:0] ref_mul(input logic [31:0] a, input logic [31:0] b,
                                          input int w, input bit s);
    longint sa, sb;
    logic [63:0] p;
    sa = longint'({32'd0, a});
    sb = longint'({32'd0, b});
    if (s && a[w-1]) sa = sa - (longint'(1) << w);
    if (s && b[w-1]) sb = sb - (longint'(1) << w);
    p = 64'(sa * sb);
    if (w < 32) p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p;
  endfunction

  function automatic void pick(input int i, input int w, output logic [31:0] a,
                               output logic [31:0] b, output bit s);
    logic [31:0] ones, mn;
    ones = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    mn   = 32'd1 << (w - 1);
    case (i)
      0: begin a = ones;  b = ones; s = 1'b0; end
      1: begin a = ones;  b = ones; s = 1'b1; end
      2: begin a = mn;    b = mn;   s = 1'b1; end
      3: begin a = mn;    b = ones; s = 1'b1; end
      4: begin a = 32'd0; b = mn;   s = 1'b1; end
      5: begin a = mn;    b = mn;   s = 1'b0; end
      default: begin
        a = $urandom() & ones;
        b = $urandom() & ones;
        s = 1'($urandom_range(0, 1));
      end
    endcase
  endfunction

  task automatic cycle8(input bit iv, input logic [7:0] a, input logic [7:0] b,
                        input bit s, input bit ordy);
    @(negedge clk);
    if (b8.out_valid) begin
      if (q8.size() == 0) chk("w8_spurious", 65'(b8.out_valid), 65'd0);
      else chk("w8_result", {b8.out_signed, 48'd0, b8.prod_high, b8.prod_low}, q8[0]);
    end
    b8.in_valid = iv; b8.in_a = a; b8.in_b = b; b8.in_signed = s; b8.out_ready = ordy;
    #1;
    if (b8.in_valid && b8.in_ready) q8.push_back({s, ref_mul({24'd0, a}, {24'd0, b}, 8, s)});
    if (b8.out_valid && b8.out_ready && q8.size() > 0) void'(q8.pop_front());
  endtask

  task automatic single8(input string tag, input logic [7:0] a, input logic [7:0] b,
                         input bit s, input logic [15:0] exp);
    cycle8(1'b1, a, b, s, 1'b1);
    cycle8(1'b0, a, b, s, 1'b1);
    chk({tag, "_lat1"}, 65'(b8.out_valid), 65'd0);
    cycle8(1'b0, a, b, s, 1'b1);
    chk({tag, "_lat2"}, 65'(b8.out_valid), 65'd1);
    chk({tag, "_prod"}, 65'({b8.prod_high, b8.prod_low}), 65'(exp));
    chk({tag, "_sgn"}, 65'(b8.out_signed), 65'(s));
  endtask

  task automatic cycle_sweep(input int i);
    logic [31:0] a, b;
    bit s;
    @(negedge clk);
    if (b4.out_valid) begin
      if (q4.size() == 0) chk("w4_spurious", 65'(b4.out_valid), 65'd0);
      else chk("w4_result", {b4.out_signed, 56'd0, b4.prod_high, b4.prod_low}, q4[0]);
    end
    if (b16.out_valid) begin
      if (q16.size() == 0) chk("w16_spurious", 65'(b16.out_valid), 65'd0);
      else chk("w16_result", {b16.out_signed, 32'd0, b16.prod_high, b16.prod_low}, q16[0]);
    end
    if (b32.out_valid) begin
      if (q32.size() == 0) chk("w32_spurious", 65'(b32.out_valid), 65'd0);
      else chk("w32_result", {b32.out_signed, b32.prod_high, b32.prod_low}, q32[0]);
    end
    b4.in_valid = (i < 512); b16.in_valid = (i < 512); b32.in_valid = (i < 512);
    b4.in_a = i[3:0]; b4.in_b = i[7:4]; b4.in_signed = i[8];
    pick(i, 16, a, b, s);
    b16.in_a = a[15:0]; b16.in_b = b[15:0]; b16.in_signed = s;
    pick(i, 32, a, b, s);
    b32.in_a = a; b32.in_b = b; b32.in_signed = s;
    #1;
    if (b4.in_valid && b4.in_ready)
      q4.push_back({b4.in_signed, ref_mul({28'd0, b4.in_a}, {28'd0, b4.in_b}, 4, b4.in_signed)});
    if (b16.in_valid && b16.in_ready)
      q16.push_back({b16.in_signed, ref_mul({16'd0, b16.in_a}, {16'd0, b16.in_b}, 16, b16.in_signed)});
    if (b32.in_valid && b32.in_ready)
      q32.push_back({b32.in_signed, ref_mul(b32.in_a, b32.in_b, 32, b32.in_signed)});
    if (b4.out_valid && q4.size() > 0) void'(q4.pop_front());
    if (b16.out_valid && q16.size() > 0) void'(q16.pop_front());
    if (b32.out_valid && q32.size() > 0) void'(q32.pop_front());
  endtask

  initial begin
    logic [7:0] a0, b0, a1, b1, a2, b2;
    bit s0, s1, s2;
    rst = 1'b1;
    b8.in_valid = 1'b0;  b8.in_a = '0;  b8.in_b = '0;  b8.in_signed = 1'b0;  b8.out_ready = 1'b1;
    b4.in_valid = 1'b0;  b4.in_a = '0;  b4.in_b = '0;  b4.in_signed = 1'b0;  b4.out_ready = 1'b1;
    b16.in_valid = 1'b0; b16.in_a = '0; b16.in_b = '0; b16.in_signed = 1'b0; b16.out_ready = 1'b1;
    b32.in_valid = 1'b0; b32.in_a = '0; b32.in_b = '0; b32.in_signed = 1'b0; b32.out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 65'(b8.out_valid), 65'd0);
    chk("rst_prod", 65'({b8.prod_high, b8.prod_low}), 65'd0);
    chk("rst_out_signed", 65'(b8.out_signed), 65'd0);
    chk("rst_in_ready", 65'(b8.in_ready), 65'd1);

    // Directed products
    single8("u_ff_ff", 8'hFF, 8'hFF, 1'b0, 16'hFE01);
    single8("u_ff_01", 8'hFF, 8'h01, 1'b0, 16'h00FF);
    single8("s_80_80", 8'h80, 8'h80, 1'b1, 16'h4000);
    single8("s_ff_01", 8'hFF, 8'h01, 1'b1, 16'hFFFF);
    single8("s_80_7f", 8'h80, 8'h7F, 1'b1, 16'hC080);
    single8("s_00_80", 8'h00, 8'h80, 1'b1, 16'h0000);

    // Back-to-back random stream
    for (int i = 0; i < 256; i++) begin
      cycle8(1'b1, 8'($urandom()), 8'($urandom()), 1'($urandom_range(0, 1)), 1'b1);
      chk("b2b_in_ready", 65'(b8.in_ready), 65'd1);
      if (i >= 2) chk("b2b_out_valid", 65'(b8.out_valid), 65'd1);
    end
    repeat (3) cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    chk("b2b_drain", 65'(q8.size()), 65'd0);

    // Backpressure
    a0 = 8'($urandom()); b0 = 8'($urandom()); s0 = 1'($urandom_range(0, 1));
    a1 = 8'($urandom()); b1 = 8'($urandom()); s1 = 1'($urandom_range(0, 1));
    a2 = 8'($urandom()); b2 = 8'($urandom()); s2 = 1'($urandom_range(0, 1));
    cycle8(1'b1, a0, b0, s0, 1'b0);
    chk("bp_rdy1", 65'(b8.in_ready), 65'd1);
    cycle8(1'b1, a1, b1, s1, 1'b0);
    chk("bp_rdy2", 65'(b8.in_ready), 65'd1);
    cycle8(1'b1, a2, b2, s2, 1'b0);
    chk("bp_rdy3", 65'(b8.in_ready), 65'd0);
    chk("bp_out_valid", 65'(b8.out_valid), 65'd1);
    repeat (3) cycle8(1'b1, a2, b2, s2, 1'b0);
    chk("bp_still_blocked", 65'(b8.in_ready), 65'd0);
    cycle8(1'b1, a2, b2, s2, 1'b1);
    chk("bp_rdy_release", 65'(b8.in_ready), 65'd1);
    repeat (4) cycle8(1'b0, a2, b2, s2, 1'b1);
    chk("bp_drain", 65'(q8.size()), 65'd0);

    // Reset with two transactions in flight
    cycle8(1'b1, 8'($urandom()), 8'($urandom()), 1'b1, 1'b1);
    cycle8(1'b1, 8'($urandom()), 8'($urandom()), 1'b0, 1'b1);
    b8.in_valid = 1'b0;
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 65'(b8.out_valid), 65'd0);
    chk("mid_rst_prod", 65'({b8.prod_high, b8.prod_low}), 65'd0);
    chk("mid_rst_out_signed", 65'(b8.out_signed), 65'd0);
    q8.delete();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle8(1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
      chk("post_rst_no_stale", 65'(b8.out_valid), 65'd0);
    end
    a0 = 8'($urandom()); b0 = 8'($urandom());
    single8("post_rst", a0, b0, 1'b1, ref_mul({24'd0, a0}, {24'd0, b0}, 8, 1'b1)[15:0]);

    // Width sweep: exhaustive at 4 bits, corners then random at 16 and 32 bits
    for (int i = 0; i < 516; i++) cycle_sweep(i);
    chk("w4_drain", 65'(q4.size()), 65'd0);
    chk("w16_drain", 65'(q16.size()), 65'd0);
    chk("w32_drain", 65'(q32.size()), 65'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/vedic_mul_pipe.md
Name: vedic_mul_pipe

Overview:
Parametrised, pipelined Urdhva-Tiryakbhyam (Vedic) multiplier. It is the next generation of the team's fixed 8-bit combinational Vedic multiplier. The product is built recursively: four WIDTH/2 sub-products are formed, then combined with carry-save addition. It adds a per-transaction signed/unsigned mode and valid/ready handshakes on input and output, so it can sit between the TT I/O capture logic and downstream consumers with backpressure.

Parameters:
WIDTH, 8, operand width in bits; power of two, minimum 4; product is 2*WIDTH bits.
BASE_W, 4, leaf multiplier width at which recursion stops; power of two, at most WIDTH.

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  operand pair present
in_ready  output  1  block accepts operands this cycle
in_a  input  WIDTH  multiplicand
in_b  input  WIDTH  multiplier
in_signed  input  1  1 = two's-complement operands, 0 = unsigned
out_valid  output  1  result present
out_ready  input  1  consumer accepts result this cycle
prod_low  output  WIDTH  product bits [WIDTH-1:0]
prod_high  output  WIDTH  product bits [2*WIDTH-1:WIDTH]
out_signed  output  1  in_signed of the transaction being presented

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high. Assertion immediately clears every pipeline valid bit. Deassertion is used synchronously.
- Reset values: out_valid=0, prod_low=0, prod_high=0, out_signed=0. in_ready=1 in the first cycle after reset release.
- Handshake: transfer occurs when valid && ready, on each side independently.
  - Once out_valid is asserted, prod_low, prod_high and out_signed hold stable until the transfer completes.
  - in_ready does not depend combinationally on in_valid.
  - in_ready may depend combinationally on out_ready.
- Pipeline: two register stages, S1 and S2, each with its own valid bit.
  - S1 captures:
    - operand magnitudes: in signed mode, |x| with MSB sign bits; in unsigned mode, the raw operand;
    - the result sign: sa XOR sb, forced to 0 in unsigned mode;
    - the mode bit;
    - the four WIDTH/2 x WIDTH/2 sub-products of the magnitudes.
  - S2 captures:
    - the combined 2*WIDTH magnitude product, with low-half pass-through plus CSA merge of the cross and high terms;
    - two's-complement negation when the result sign is 1.
  - S2 drives the outputs directly.
- Latency: 2 cycles from input transfer to out_valid with no stall. Throughput is 1 result/cycle while out_ready=1.
- Stall rules:
  - S2 advances when !s2_valid || out_ready.
  - S1 advances when !s1_valid || S2 advances.
  - in_ready = S1 advances.
  - Maximum 2 transactions in flight; with out_ready held low, in_ready drops after 2 accepts.
  - No transaction is dropped or duplicated. Order is preserved.
- Arithmetic:
  - Unsigned: result = in_a*in_b over 2*WIDTH bits, exact.
  - Signed: result = two's-complement in_a*in_b over 2*WIDTH bits, exact. The most-negative x most-negative case is included (magnitude 2^(WIDTH-1) fits in WIDTH unsigned bits).
  - A zero product is never negated to a nonzero value.
- Recursion: sub-products below WIDTH use the same decomposition down to BASE_W leaves. Leaf products are combinational within S1.
- Simultaneous events: with both stages full and out_ready=1, an input transfer, an S1->S2 move and an output transfer all occur in the same cycle.
- Reset mid-operation: all in-flight transactions are discarded, with no output produced for them.
- Operand and mode inputs are don't-care when in_valid=0. They are never sampled unless in_ready=1.

Test Plan:
1. WIDTH=8, unsigned 0xFF*0xFF -> after 2 cycles out_valid=1, prod_high=0xFE, prod_low=0x01; unsigned 0xFF*0x01 -> 0x00FF.
2. Signed: 0x80*0x80 -> 0x4000; 0xFF*0x01 -> 0xFFFF; 0x80*0x7F -> 0xC080; 0x00*0x80 -> 0x0000. Check out_signed=1 for each.
3. Back-to-back: 256 random unsigned/signed operand pairs with out_ready=1 and in_valid=1 every cycle -> one result per cycle, in order, matching the reference model.
4. Backpressure: out_ready=0 and 3 pairs offered -> exactly 2 accepted, in_ready=0 on the 3rd; outputs held stable. out_ready=1 -> results drain in order, 3rd accepted the same cycle the first result transfers.
5. Reset mid-operation: assert rst asynchronously (between clk edges) with 2 transactions in flight -> out_valid=0 and outputs=0 immediately; after release, no stale result appears and the next transaction returns in 2 cycles.
6. Parameter sweep: WIDTH=4,16,32 with BASE_W=4 -> exhaustive check at WIDTH=4 and random check at 16/32. Corners: all-ones, most-negative, zero.
